imem_prefetch_buf: RTL and testbench

Instruction prefetch buffer between the scalar core's fetch stage and the instruction port of the memory subsystem. It issues sequential word fetches on the req/ready memory handshake and queues returned instructions with their PCs in a small FIFO. It presents them to the core as a valid/ready stream. A flush (branch or jump redirect) discards queued and in-flight instructions and restarts fetch at a new PC.

---
 rtl/imem_prefetch_buf.sv | 153 +++++++++++++++
 tb/tb_imem_prefetch_buf.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prefetch_buf.sv
// rtl/imem_prefetch_buf.sv - sequential instruction prefetch FIFO with flush/redirect
module imem_prefetch_buf #(
  parameter int                DWidth  = 32,
  parameter int                Depth   = 4,
  parameter logic [DWidth-1:0] ResetPc = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [DWidth-1:0]      flush_pc_i,
  output logic                   instr_valid_o,
  output logic [DWidth-1:0]      instr_o,
  output logic [DWidth-1:0]      instr_pc_o,
  input  logic                   instr_ready_i,
  output logic                   imem_req_o,
  output logic [DWidth-1:0]      imem_addr_o,
  input  logic                   imem_ready_i,
  input  logic [DWidth-1:0]      imem_rdata_i,
  output logic [$clog2(Depth):0] count_o
);

  localparam int                PW     = $clog2(Depth);
  localparam int                CW     = PW + 1;
  localparam logic [CW-1:0]     DepthC = CW'(Depth);
  localparam logic [DWidth-1:0] PcStep = DWidth'(4);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t            state_q, state_d;
  logic [DWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_d;
  logic [DWidth-1:0] addr_d;

  logic [DWidth-1:0] data_mem [Depth];
  logic [DWidth-1:0] pc_mem   [Depth];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_after;
  logic              push, pop;

  // A flush hides the head in its own cycle so the core never consumes a stale entry.
  assign instr_valid_o = (count_q != '0) && !flush_i;
  assign pop           = instr_valid_o && instr_ready_i;
  // While in REQ the request is always raised, so ready here completes our fetch.
  assign push          = (state_q == REQ) && imem_ready_i && !flush_i;
  assign count_after   = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  assign instr_o    = data_mem[rd_ptr_q];
  assign instr_pc_o = pc_mem[rd_ptr_q];
  assign count_o    = count_q;

  // Next-state and registered request outputs; fetch_pc tracks imem_addr_o while in REQ.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = imem_req_o;
    addr_d     = imem_addr_o;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          fetch_pc_d = flush_pc_i;
          state_d    = REQ;
          req_d      = 1'b1;
          addr_d     = flush_pc_i;
        end else if (count_q < DepthC) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (flush_i) begin
          fetch_pc_d = flush_pc_i;
          if (imem_ready_i) begin
            addr_d = flush_pc_i;
          end else begin
            state_d = DROP;
          end
        end else if (imem_ready_i) begin
          fetch_pc_d = fetch_pc_q + PcStep;
          if (count_after < DepthC) begin
            addr_d = fetch_pc_q + PcStep;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DROP: begin
        if (flush_i) begin
          fetch_pc_d = flush_pc_i;
        end
        if (imem_ready_i) begin
          state_d = REQ;
          addr_d  = flush_i ? flush_pc_i : fetch_pc_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state, fetch PC and memory-side request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= ResetPc;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_o  <= req_d;
      imem_addr_o <= addr_d;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue ahead of push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_after;
    end
  end

  // Entry storage: instruction word with the address it was fetched from.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]   <= imem_addr_o;
    end
  end

endmodule

// File: tb/tb_imem_prefetch_buf.sv
// tb/tb_imem_prefetch_buf.sv - directed self-checking bench for imem_prefetch_buf
module tb_imem_prefetch_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic [DW-1:0] flush_pc_i = '0;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [DW-1:0] instr_pc_o;
  logic          instr_ready_i = 1'b0;
  logic          imem_req_o;
  logic [DW-1:0] imem_addr_o;
  logic          imem_ready_i;
  logic [DW-1:0] imem_rdata_i;
  logic [CW-1:0] count_o;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 0;
  int wait_cnt = 0;
  int n_fetch  = 0;

  imem_prefetch_buf #(
    .DWidth (DW),
    .Depth  (DEPTH),
    .ResetPc(32'h0000_0000)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Main stimulus acts at posedge+2; memory model acts at posedge+1.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    instr_ready_i = 1'b0;
    mem_lat       = 0;
    tick();
    tick();
    chk("rst_req",   32'(imem_req_o), 0);
    chk("rst_addr",  imem_addr_o, 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(instr_valid_o), 0);
    rst_i   = 1'b0;
    n_fetch = 0;
  endtask

  // Memory model: answers a held request after mem_lat waiting cycles.
  initial begin
    imem_ready_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      imem_ready_i = 1'b0;
      if (imem_req_o && !rst_i) begin
        if (wait_cnt >= mem_lat) begin
          imem_ready_i = 1'b1;
          imem_rdata_i = word_of(imem_addr_o);
          wait_cnt     = 0;
          n_fetch++;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    int          exp_cnt;
    bit          seen_ready;

    // Back-to-back fetch with a consuming core.
    do_reset();
    instr_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t1_req",  32'(imem_req_o), 1);
      chk("t1_addr", imem_addr_o, 32'(4 * i));
      if (i == 0) begin
        chk("t1_valid0", 32'(instr_valid_o), 0);
        chk("t1_count0", 32'(count_o), 0);
      end else begin
        chk("t1_valid", 32'(instr_valid_o), 1);
        chk("t1_pc",    instr_pc_o, 32'(4 * (i - 1)));
        chk("t1_instr", instr_o, word_of(32'(4 * (i - 1))));
        chk("t1_count", 32'(count_o), 1);
      end
      tick();
    end

    // Stalled core: reservation stops after Depth fetches; one pop allows one more.
    do_reset();
    repeat (12) tick();
    chk("t2_nfetch", 32'(n_fetch), 4);
    chk("t2_req",    32'(imem_req_o), 0);
    chk("t2_count",  32'(count_o), 4);
    chk("t2_pc",     instr_pc_o, 32'h0);
    chk("t2_instr",  instr_o, word_of(32'h0));
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("t2_pop_count", 32'(count_o), 3);
    chk("t2_pop_pc",    instr_pc_o, 32'h4);
    chk("t2_pop_req",   32'(imem_req_o), 0);
    tick();
    chk("t2_refetch_req",  32'(imem_req_o), 1);
    chk("t2_refetch_addr", imem_addr_o, 32'h10);
    tick();
    chk("t2_full_count", 32'(count_o), 4);
    chk("t2_full_req",   32'(imem_req_o), 0);
    chk("t2_nfetch5",    32'(n_fetch), 5);
    repeat (3) tick();
    chk("t2_no_extra",   32'(n_fetch), 5);

    // Flush while a slow request is outstanding: hold it, drop its data, redirect.
    do_reset();
    tick();
    tick();
    mem_lat = 3;
    tick();
    chk("t3_addr8",  imem_addr_o, 32'h8);
    chk("t3_count2", 32'(count_o), 2);
    flush_i    = 1'b1;
    flush_pc_i = 32'h100;
    #1;
    chk("t3_valid_flush", 32'(instr_valid_o), 0);
    tick();
    flush_i = 1'b0;
    chk("t3_drop_count", 32'(count_o), 0);
    chk("t3_drop_valid", 32'(instr_valid_o), 0);
    seen_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_req",  32'(imem_req_o), 1);
      chk("t3_hold_addr", imem_addr_o, 32'h8);
      if (imem_ready_i) begin
        seen_ready = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_ready_seen", 32'(seen_ready), 1);
    mem_lat = 0;
    tick();
    chk("t3_redirect_req",  32'(imem_req_o), 1);
    chk("t3_redirect_addr", imem_addr_o, 32'h100);
    chk("t3_discarded",     32'(count_o), 0);
    tick();
    chk("t3_first_valid", 32'(instr_valid_o), 1);
    chk("t3_first_pc",    instr_pc_o, 32'h100);
    chk("t3_first_instr", instr_o, word_of(32'h100));

    // Flush coincident with a memory response and a ready core.
    do_reset();
    tick();
    tick();
    tick();
    instr_ready_i = 1'b1;
    tick();
    chk("t4_addrC", imem_addr_o, 32'hC);
    chk("t4_count", 32'(count_o), 2);
    chk("t4_head",  instr_pc_o, 32'h4);
    flush_i    = 1'b1;
    flush_pc_i = 32'h200;
    #1;
    chk("t4_valid_flush", 32'(instr_valid_o), 0);
    tick();
    flush_i       = 1'b0;
    instr_ready_i = 1'b0;
    chk("t4_count0", 32'(count_o), 0);
    chk("t4_req",    32'(imem_req_o), 1);
    chk("t4_addr",   imem_addr_o, 32'h200);
    tick();
    chk("t4_count1", 32'(count_o), 1);
    chk("t4_pc",     instr_pc_o, 32'h200);

    // Drain from full while refetching: order preserved across pointer wrap.
    do_reset();
    repeat (8) tick();
    chk("t5_full", 32'(count_o), 4);
    instr_ready_i = 1'b1;
    exp_pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      exp_cnt = (k == 0) ? 4 : (k == 1) ? 3 : 2;
      chk("t5_valid", 32'(instr_valid_o), 1);
      chk("t5_pc",    instr_pc_o, exp_pc);
      chk("t5_instr", instr_o, word_of(exp_pc));
      chk("t5_count", 32'(count_o), 32'(exp_cnt));
      exp_pc = exp_pc + 32'h4;
      tick();
    end
    instr_ready_i = 1'b0;

    // Asynchronous reset mid-request, then PC wrap on redirect.
    do_reset();
    tick();
    tick();
    mem_lat = 5;
    tick();
    tick();
    chk("t6_req_before",  32'(imem_req_o), 1);
    chk("t6_addr_before", imem_addr_o, 32'h8);
    rst_i = 1'b1;
    #1;
    chk("t6_req_async",   32'(imem_req_o), 0);
    chk("t6_addr_async",  imem_addr_o, 32'h0);
    chk("t6_count_async", 32'(count_o), 0);
    tick();
    rst_i   = 1'b0;
    mem_lat = 0;
    tick();
    chk("t6_restart_req",  32'(imem_req_o), 1);
    chk("t6_restart_addr", imem_addr_o, 32'h0);
    flush_i    = 1'b1;
    flush_pc_i = 32'hFFFF_FFFC;
    tick();
    flush_i = 1'b0;
    chk("t6_wrap_req",  32'(imem_req_o), 1);
    chk("t6_wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_next", imem_addr_o, 32'h0);
    chk("t6_wrap_pc",   instr_pc_o, 32'hFFFF_FFFC);
    chk("t6_wrap_data", instr_o, word_of(32'hFFFF_FFFC));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
